axis_sample_checker: RTL and testbench

Stream monitor and register slice between `sample_generator` and the AXI DMA S2MM slave port. It forwards every beat unchanged and checks two things on the input stream:
- the data follows the counting sequence (each word equals the previous word plus one);
- packet lengths match the programmed TLAST spacing.

It keeps saturating error counters, free-running beat and packet counters, and a sticky error flag with a capture of the first offending word, all readable by the PS through an AXI-Lite wrapper.

---
 rtl/axis_sample_checker_pkg.sv | 22 ++
 rtl/axis_sample_checker_if.sv | 28 ++
 rtl/axis_sample_checker_skid_buffer.sv | 94 +++++++++
 rtl/axis_sample_checker.sv | 156 +++++++++++++++
 tb/tb_axis_sample_checker.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_sample_checker_pkg.sv
// ---------------------------------------------------------------------------
// axis_checker_pkg
// Shared types and constants for the AXI-Stream sample checker slice.
//   state_t          : checker state (ST_SYNC waits for a first beat to lock
//                      onto, ST_TRACK compares each beat against the last+1)
//   MAX_DATA_WIDTH   : upper bound on the stream width the constants cover
//   ERR_COUNT_SAT    : saturation value for error counters (slice to width)
//   TKEEP_RESET      : value driven on TKEEP while no beat is held (slice)
// ---------------------------------------------------------------------------
package axis_checker_pkg;

  typedef enum logic {
    ST_SYNC,
    ST_TRACK
  } state_t;

  localparam int MAX_DATA_WIDTH = 1024;

  localparam logic [MAX_DATA_WIDTH-1:0]   ERR_COUNT_SAT = '1;
  localparam logic [MAX_DATA_WIDTH/8-1:0] TKEEP_RESET   = '1;

endpackage

// File: rtl/axis_sample_checker_if.sv
// ---------------------------------------------------------------------------
// axis_sample_checker_if
// One AXI-Stream link (data, keep, last, valid, ready).
//   master modport : drives tdata/tkeep/tlast/tvalid, samples tready
//   slave  modport : samples tdata/tkeep/tlast/tvalid, drives tready
// Parameter W is the TDATA width; TKEEP is W/8 bits.
// ---------------------------------------------------------------------------
interface axis_sample_checker_if #(
  parameter int W = 32
) ();

  logic [W-1:0]   tdata;
  logic [W/8-1:0] tkeep;
  logic           tlast;
  logic           tvalid;
  logic           tready;

  modport master (
    output tdata, tkeep, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tlast, tvalid,
    output tready
  );

endinterface

// File: rtl/axis_sample_checker_skid_buffer.sv
// ---------------------------------------------------------------------------
// axis_skid_buffer
// Two-entry AXI-Stream register slice: a main register feeding the M side
// and a skid register that catches the one beat accepted in the cycle the
// downstream stalls. Every output, including s_tready, comes from a flop.
// Ports:
//   ACLK, ARESETN                         : clock, synchronous active-low reset
//   s_tdata/s_tkeep/s_tlast/s_tvalid      : upstream beat
//   s_tready                              : upstream ready (low while skid full)
//   m_tdata/m_tkeep/m_tlast/m_tvalid      : downstream beat
//   m_tready                              : downstream ready
// ---------------------------------------------------------------------------
module axis_skid_buffer
  import axis_checker_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           ACLK,
  input  logic           ARESETN,
  input  logic [W-1:0]   s_tdata,
  input  logic [W/8-1:0] s_tkeep,
  input  logic           s_tlast,
  input  logic           s_tvalid,
  output logic           s_tready,
  output logic [W-1:0]   m_tdata,
  output logic [W/8-1:0] m_tkeep,
  output logic           m_tlast,
  output logic           m_tvalid,
  input  logic           m_tready
);

  logic [W-1:0]   skid_data;
  logic [W/8-1:0] skid_keep;
  logic           skid_last;
  logic           skid_valid;
  logic           s_acc;
  logic           main_free;
  logic           skid_valid_next;

  assign s_acc     = s_tvalid && s_tready;
  assign main_free = !m_tvalid || m_tready;

  // The skid slot drains whenever the main register can move, and fills when
  // a beat is accepted while the main register is stuck. Ready is the
  // registered inverse of that next occupancy, so upstream sees a clean flop.
  always_comb begin
    skid_valid_next = skid_valid;
    if (main_free) begin
      skid_valid_next = 1'b0;
    end else if (s_acc) begin
      skid_valid_next = 1'b1;
    end
  end

  // Main register loads from the skid slot first (older beat) so ordering is
  // preserved; otherwise straight from the input. A stalled main register
  // holds every M-side output untouched.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      m_tdata    <= '0;
      m_tkeep    <= TKEEP_RESET[W/8-1:0];
      m_tlast    <= 1'b0;
      m_tvalid   <= 1'b0;
      skid_data  <= '0;
      skid_keep  <= TKEEP_RESET[W/8-1:0];
      skid_last  <= 1'b0;
      skid_valid <= 1'b0;
      s_tready   <= 1'b0;
    end else begin
      skid_valid <= skid_valid_next;
      s_tready   <= !skid_valid_next;
      if (main_free) begin
        if (skid_valid) begin
          m_tdata  <= skid_data;
          m_tkeep  <= skid_keep;
          m_tlast  <= skid_last;
          m_tvalid <= 1'b1;
        end else if (s_acc) begin
          m_tdata  <= s_tdata;
          m_tkeep  <= s_tkeep;
          m_tlast  <= s_tlast;
          m_tvalid <= 1'b1;
        end else begin
          m_tvalid <= 1'b0;
        end
      end else if (s_acc) begin
        skid_data <= s_tdata;
        skid_keep <= s_tkeep;
        skid_last <= s_tlast;
      end
    end
  end

endmodule

// File: rtl/axis_sample_checker.sv
// ---------------------------------------------------------------------------
// axis_sample_checker
// Forwards an AXI-Stream unchanged and watches the input side: data must
// count up by one per beat and TLAST must land every tlast_throttle beats.
// Keeps saturating error counters, wrapping beat/packet counters, a sticky
// error flag and the data of the first offending beat since clear.
// Build option: define AXIS_SKID_EN for a registered 2-entry skid slice on
// the data path; otherwise the stream is a combinational pass-through.
// Ports:
//   ACLK, ARESETN     : clock, synchronous active-low reset
//   enable            : checking active (beats always pass through)
//   clear             : pulse, zeroes counters/sticky and resynchronises
//   tlast_throttle    : expected beats per packet, 0 disables length check
//   s_axis (slave)    : upstream stream
//   m_axis (master)   : downstream stream
//   seq_err_count     : sequence mismatches, saturating
//   len_err_count     : packet-length mismatches, saturating
//   beat_count        : checked beats, wrapping
//   packet_count      : checked TLAST beats, wrapping
//   error_sticky      : any error since clear/reset
//   first_err_data    : TDATA of the first erroring beat
// ---------------------------------------------------------------------------
module axis_sample_checker
  import axis_checker_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH = 32
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic                         enable,
  input  logic                         clear,
  input  logic [C_AXIS_DATA_WIDTH-1:0] tlast_throttle,
  axis_sample_checker_if.slave         s_axis,
  axis_sample_checker_if.master        m_axis,
  output logic [C_AXIS_DATA_WIDTH-1:0] seq_err_count,
  output logic [C_AXIS_DATA_WIDTH-1:0] len_err_count,
  output logic [C_AXIS_DATA_WIDTH-1:0] beat_count,
  output logic [C_AXIS_DATA_WIDTH-1:0] packet_count,
  output logic                         error_sticky,
  output logic [C_AXIS_DATA_WIDTH-1:0] first_err_data
);

  localparam int W = C_AXIS_DATA_WIDTH;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] SAT = ERR_COUNT_SAT[W-1:0];

  logic         s_ready;
  logic         acc;
  state_t       state;
  logic [W-1:0] expected;
  logic [W-1:0] len_cnt;
  logic [W-1:0] len_next;
  logic         seq_err;
  logic         len_err;

  // Data path: registered slice or plain wires, chosen at build time.
`ifdef AXIS_SKID_EN
  logic [W-1:0]   m_data;
  logic [W/8-1:0] m_keep;
  logic           m_last;
  logic           m_valid;

  axis_skid_buffer #(
    .W(W)
  ) u_skid (
    .ACLK     (ACLK),
    .ARESETN  (ARESETN),
    .s_tdata  (s_axis.tdata),
    .s_tkeep  (s_axis.tkeep),
    .s_tlast  (s_axis.tlast),
    .s_tvalid (s_axis.tvalid),
    .s_tready (s_ready),
    .m_tdata  (m_data),
    .m_tkeep  (m_keep),
    .m_tlast  (m_last),
    .m_tvalid (m_valid),
    .m_tready (m_axis.tready)
  );

  assign m_axis.tdata  = m_data;
  assign m_axis.tkeep  = m_keep;
  assign m_axis.tlast  = m_last;
  assign m_axis.tvalid = m_valid;
`else
  assign m_axis.tdata  = s_axis.tdata;
  assign m_axis.tkeep  = s_axis.tkeep;
  assign m_axis.tlast  = s_axis.tlast;
  assign m_axis.tvalid = s_axis.tvalid;
  assign s_ready       = m_axis.tready;
`endif

  assign s_axis.tready = s_ready;
  assign acc           = s_axis.tvalid && s_ready;

  // Error conditions for the current input beat; they only matter in TRACK.
  // The length check counts the TLAST beat itself, hence len_cnt + 1.
  assign len_next = len_cnt + ONE;
  assign seq_err  = (s_axis.tdata != expected);
  assign len_err  = s_axis.tlast && (tlast_throttle != '0) &&
                    (len_next != tlast_throttle);

  // Checker state machine and counters. Clear outranks a same-cycle beat, so
  // that beat is forwarded but never looked at, and the following beat is
  // taken in SYNC. Expected is always reloaded from the received data, which
  // means a single glitch costs one error and the check relocks immediately.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state          <= ST_SYNC;
      expected       <= '0;
      len_cnt        <= '0;
      seq_err_count  <= '0;
      len_err_count  <= '0;
      beat_count     <= '0;
      packet_count   <= '0;
      error_sticky   <= 1'b0;
      first_err_data <= '0;
    end else if (clear) begin
      state          <= ST_SYNC;
      len_cnt        <= '0;
      seq_err_count  <= '0;
      len_err_count  <= '0;
      beat_count     <= '0;
      packet_count   <= '0;
      error_sticky   <= 1'b0;
    end else if (!enable) begin
      state <= ST_SYNC;
    end else if (acc) begin
      beat_count <= beat_count + ONE;
      expected   <= s_axis.tdata + ONE;
      if (s_axis.tlast) begin
        packet_count <= packet_count + ONE;
      end
      case (state)
        ST_SYNC: begin
          len_cnt <= s_axis.tlast ? '0 : ONE;
          state   <= ST_TRACK;
        end
        ST_TRACK: begin
          len_cnt <= s_axis.tlast ? '0 : len_next;
          if (seq_err && (seq_err_count != SAT)) begin
            seq_err_count <= seq_err_count + ONE;
          end
          if (len_err && (len_err_count != SAT)) begin
            len_err_count <= len_err_count + ONE;
          end
          if ((seq_err || len_err) && !error_sticky) begin
            error_sticky   <= 1'b1;
            first_err_data <= s_axis.tdata;
          end
        end
        default: state <= ST_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_sample_checker.sv
// ---------------------------------------------------------------------------
// tb_axis_sample_checker
// Directed bench for axis_sample_checker. Beats accepted on the S side are
// queued and compared against what leaves the M side; counters and flags
// are compared against hand-derived values after each scenario.
// Works for both builds (AXIS_SKID_EN defined or not).
// ---------------------------------------------------------------------------
module tb_axis_sample_checker;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0]   data;
    logic [W/8-1:0] keep;
    logic           last;
  } beat_t;

  logic         ACLK;
  logic         ARESETN;
  logic         enable;
  logic         clear;
  logic [W-1:0] tlast_throttle;
  logic [W-1:0] seq_err_count;
  logic [W-1:0] len_err_count;
  logic [W-1:0] beat_count;
  logic [W-1:0] packet_count;
  logic         error_sticky;
  logic [W-1:0] first_err_data;

  int compared_count = 0;
  int mismatch_count = 0;

  beat_t sb[$];

  axis_sample_checker_if #(.W(W)) s_axis ();
  axis_sample_checker_if #(.W(W)) m_axis ();

  axis_sample_checker #(
    .C_AXIS_DATA_WIDTH(W)
  ) dut (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .enable         (enable),
    .clear          (clear),
    .tlast_throttle (tlast_throttle),
    .s_axis         (s_axis),
    .m_axis         (m_axis),
    .seq_err_count  (seq_err_count),
    .len_err_count  (len_err_count),
    .beat_count     (beat_count),
    .packet_count   (packet_count),
    .error_sticky   (error_sticky),
    .first_err_data (first_err_data)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check_output(input string tag, input logic [W-1:0] observed,
                              input logic [W-1:0] expected);
    compared_count++;
    assert (observed === expected) else begin
      mismatch_count++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Scoreboard: record S-side handshakes, compare M-side handshakes in order.
  // Sampled on the falling edge, halfway between active edges.
  always @(negedge ACLK) begin
    beat_t got;
    beat_t exp_beat;
    if (ARESETN) begin
      if (s_axis.tvalid && s_axis.tready) begin
        sb.push_back('{data: s_axis.tdata, keep: s_axis.tkeep, last: s_axis.tlast});
      end
      if (m_axis.tvalid && m_axis.tready) begin
        got = '{data: m_axis.tdata, keep: m_axis.tkeep, last: m_axis.tlast};
        if (sb.size() == 0) begin
          check_output("sb_unexpected_beat", got.data, 'x);
        end else begin
          exp_beat = sb.pop_front();
          check_output("m_tdata", got.data, exp_beat.data);
          check_output("m_tkeep", W'(got.keep), W'(exp_beat.keep));
          check_output("m_tlast", W'(got.last), W'(exp_beat.last));
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded), returning just
  // after the accepting edge with TVALID still high for back-to-back use.
  task automatic apply_stimulus(input logic [W-1:0] d, input logic l);
    logic accepted;
    s_axis.tdata  = d;
    s_axis.tkeep  = 4'($urandom_range(0, 15));
    s_axis.tlast  = l;
    s_axis.tvalid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge ACLK);
      if (s_axis.tready) accepted = 1'b1;
    end
    @(posedge ACLK);
    #1;
    if (!accepted) check_output("send_timeout", W'(accepted), W'(1'b1));
  endtask

  task automatic go_idle();
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  task automatic pulse_clear();
    go_idle();
    clear = 1'b1;
    wait_cycles(1);
    clear = 1'b0;
  endtask

  initial begin
    logic exp_ready_reset;
    ARESETN        = 1'b0;
    enable         = 1'b0;
    clear          = 1'b0;
    tlast_throttle = '0;
    s_axis.tdata   = '0;
    s_axis.tkeep   = '1;
    s_axis.tlast   = 1'b0;
    s_axis.tvalid  = 1'b0;
    m_axis.tready  = 1'b1;
`ifdef AXIS_SKID_EN
    exp_ready_reset = 1'b0;
`else
    exp_ready_reset = 1'b1;
`endif

    // Reset state
    wait_cycles(4);
    check_output("rst_seq_err", seq_err_count, '0);
    check_output("rst_len_err", len_err_count, '0);
    check_output("rst_beats", beat_count, '0);
    check_output("rst_packets", packet_count, '0);
    check_output("rst_sticky", W'(error_sticky), '0);
    check_output("rst_first_err", first_err_data, '0);
    check_output("rst_m_tvalid", W'(m_axis.tvalid), '0);
    check_output("rst_m_tdata", m_axis.tdata, '0);
    check_output("rst_m_tlast", W'(m_axis.tlast), '0);
    check_output("rst_m_tkeep", W'(m_axis.tkeep), 32'hF);
    check_output("rst_s_tready", W'(s_axis.tready), W'(exp_ready_reset));
    ARESETN = 1'b1;
    wait_cycles(1);
    check_output("post_rst_s_tready", W'(s_axis.tready), 32'd1);

    // Counting run 0..15, TLAST every 4th beat
    enable = 1'b1;
    tlast_throttle = 32'd4;
    for (int i = 0; i < 16; i++) apply_stimulus(W'(i), (i % 4) == 3);
    go_idle();
    wait_cycles(3);
    check_output("cnt_beats", beat_count, 32'd16);
    check_output("cnt_packets", packet_count, 32'd4);
    check_output("cnt_seq_err", seq_err_count, '0);
    check_output("cnt_len_err", len_err_count, '0);
    check_output("cnt_sticky", W'(error_sticky), '0);

    // Inserted error: 0,1,2,3,3,6,7
    pulse_clear();
    tlast_throttle = '0;
    apply_stimulus(32'd0, 1'b0);
    apply_stimulus(32'd1, 1'b0);
    apply_stimulus(32'd2, 1'b0);
    apply_stimulus(32'd3, 1'b0);
    apply_stimulus(32'd3, 1'b0);
    apply_stimulus(32'd6, 1'b0);
    apply_stimulus(32'd7, 1'b0);
    go_idle();
    wait_cycles(2);
    check_output("ins_seq_err", seq_err_count, 32'd2);
    check_output("ins_first_err", first_err_data, 32'd3);
    check_output("ins_sticky", W'(error_sticky), 32'd1);
    check_output("ins_beats", beat_count, 32'd7);
    check_output("ins_len_err", len_err_count, '0);

    // Short packet with throttle 4, then a good packet
    pulse_clear();
    tlast_throttle = 32'd4;
    apply_stimulus(32'd0, 1'b0);
    apply_stimulus(32'd1, 1'b0);
    apply_stimulus(32'd2, 1'b1);
    go_idle();
    wait_cycles(2);
    check_output("short_len_err", len_err_count, 32'd1);
    check_output("short_first_err", first_err_data, 32'd2);
    check_output("short_packets", packet_count, 32'd1);
    for (int i = 3; i < 7; i++) apply_stimulus(W'(i), i == 6);
    go_idle();
    wait_cycles(2);
    check_output("good_len_err", len_err_count, 32'd1);
    check_output("good_packets", packet_count, 32'd2);
    check_output("good_seq_err", seq_err_count, '0);

    // Same short packet with the length check disabled
    pulse_clear();
    tlast_throttle = '0;
    apply_stimulus(32'd0, 1'b0);
    apply_stimulus(32'd1, 1'b0);
    apply_stimulus(32'd2, 1'b1);
    go_idle();
    wait_cycles(2);
    check_output("nolen_len_err", len_err_count, '0);
    check_output("nolen_sticky", W'(error_sticky), '0);

    // Clear together with beat 100 after errors, then resync on 57
    apply_stimulus(32'd9, 1'b0);
    go_idle();
    wait_cycles(1);
    check_output("pre_clr_sticky", W'(error_sticky), 32'd1);
    clear = 1'b1;
    apply_stimulus(32'd100, 1'b0);
    clear = 1'b0;
    go_idle();
    check_output("clr_seq_err", seq_err_count, '0);
    check_output("clr_beats", beat_count, '0);
    check_output("clr_packets", packet_count, '0);
    check_output("clr_sticky", W'(error_sticky), '0);
    apply_stimulus(32'd57, 1'b0);
    apply_stimulus(32'd58, 1'b0);
    apply_stimulus(32'd59, 1'b0);
    go_idle();
    wait_cycles(2);
    check_output("resync_seq_err", seq_err_count, '0);
    check_output("resync_sticky", W'(error_sticky), '0);
    check_output("resync_beats", beat_count, 32'd3);

`ifdef AXIS_SKID_EN
    // Backpressure: downstream stalled for 5 cycles mid-stream
    m_axis.tready = 1'b0;
    apply_stimulus(32'd60, 1'b0);
    apply_stimulus(32'd61, 1'b0);
    check_output("bp_s_tready_low", W'(s_axis.tready), '0);
    s_axis.tdata = 32'd62;
    for (int i = 0; i < 3; i++) begin
      wait_cycles(1);
      check_output("bp_m_tvalid_hold", W'(m_axis.tvalid), 32'd1);
      check_output("bp_m_tdata_hold", m_axis.tdata, 32'd60);
      check_output("bp_s_tready_hold", W'(s_axis.tready), '0);
    end
    m_axis.tready = 1'b1;
    apply_stimulus(32'd62, 1'b0);
    apply_stimulus(32'd63, 1'b0);
    go_idle();
    wait_cycles(4);
    check_output("bp_seq_err", seq_err_count, '0);
    check_output("bp_beats", beat_count, 32'd7);
`endif

    // Saturation: preload the sequence error counter, then mismatch
    force dut.seq_err_count = 32'hFFFF_FFFF;
    wait_cycles(1);
    release dut.seq_err_count;
    apply_stimulus(32'd5, 1'b0);
    go_idle();
    wait_cycles(2);
    check_output("sat_seq_err", seq_err_count, 32'hFFFF_FFFF);
    check_output("sat_sticky", W'(error_sticky), 32'd1);
    check_output("sat_first_err", first_err_data, 32'd5);

    // Enable low: beats pass but are neither checked nor counted
    enable = 1'b0;
    for (int i = 0; i < 4; i++) apply_stimulus(W'(1000 + 3 * i), 1'b1);
    go_idle();
    wait_cycles(4);
    check_output("dis_packets", packet_count, '0);
    check_output("dis_seq_err", seq_err_count, 32'hFFFF_FFFF);

    // Everything sent must have come out
    check_output("sb_drained", W'(sb.size()), '0);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***",
             compared_count, mismatch_count);
    $finish;
  end

endmodule
